// File: rtl/if_fetch_queue.sv
// Prefetch FIFO between the instruction ROM and the IF/ID stage.
// Holds (pc, inst, misaligned) entries and asks the PC register to stall before overflow.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exc_adel,
  input  logic              out_ready,
  output logic              stall_req,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              flush_pend;
  logic              pop, push, drop, accept_ok;

  assign out_valid = (count != '0);
  assign head      = mem[rd_ptr];

  // Empty queue presents a NOP so decode never sees stale storage.
  always_comb begin
    out_pc       = '0;
    out_inst     = '0;
    out_exc_adel = 1'b0;
    if (out_valid) begin
      out_pc       = head.pc;
      out_inst     = head.inst;
      out_exc_adel = head.adel;
    end
  end

  // A response arriving during or right after a flush belongs to the killed stream.
  assign accept_ok = in_valid && !flush && !flush_pend;
  assign pop       = out_valid && out_ready;
  assign push      = accept_ok && ((count < FULL_CNT) || pop);
  assign drop      = accept_ok && (count == FULL_CNT) && !pop;

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      stall_req  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count      <= count_next;
      flush_pend <= flush;
      // One slot of slack covers the read issued before the PC register sees the stall.
      stall_req  <= !flush && (count_next >= STALL_CNT);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, adel: (in_pc[1:0] != 2'b00)};
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed test of if_fetch_queue: fill/stall, full push+pop, overflow, flush kill, misalignment.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        out_valid, out_exc_adel, stall_req, overflow;
  logic [31:0] out_pc, out_inst;

  int checks = 0;
  int failures = 0;

  if_fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_exc_adel(out_exc_adel), .out_ready(out_ready), .stall_req(stall_req),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    fetch(1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_inst",  out_inst, 0);
    chk("rst_stall", 32'(stall_req), 0);
    chk("rst_ovf",   32'(overflow), 0);
    rst = 1'b0;

    // Fill with decode blocked
    fetch(1'b1, 32'h0, 1'b0); tick();
    chk("fill1_valid", 32'(out_valid), 1);
    chk("fill1_pc",    out_pc, 32'h0);
    chk("fill1_stall", 32'(stall_req), 0);
    fetch(1'b1, 32'h4, 1'b0); tick();
    chk("fill2_stall", 32'(stall_req), 0);
    fetch(1'b1, 32'h8, 1'b0); tick();
    chk("fill3_stall", 32'(stall_req), 1);
    chk("fill3_head",  out_pc, 32'h0);
    fetch(1'b1, 32'hC, 1'b0); tick();
    chk("fill4_stall", 32'(stall_req), 1);
    chk("fill4_ovf",   32'(overflow), 0);

    // Full: push and pop together reuse the freed slot
    fetch(1'b1, 32'h10, 1'b1); tick();
    chk("fullpp_head", out_pc, 32'h4);
    chk("fullpp_ovf",  32'(overflow), 0);
    chk("fullpp_stall", 32'(stall_req), 1);

    // Full and blocked: response dropped
    fetch(1'b1, 32'h14, 1'b0); tick();
    chk("drop_ovf",  32'(overflow), 1);
    chk("drop_head", out_pc, 32'h4);

    // Drain: expect 4, 8, C, 10 then empty
    fetch(1'b0, 32'h0, 1'b1);
    chk("drain0_pc",   out_pc, 32'h4);
    chk("drain0_inst", out_inst, inst_of(32'h4));
    tick();
    chk("drain1_pc",    out_pc, 32'h8);
    chk("drain1_stall", 32'(stall_req), 1);
    tick();
    chk("drain2_pc",    out_pc, 32'hC);
    chk("drain2_stall", 32'(stall_req), 0);
    tick();
    chk("drain3_pc",   out_pc, 32'h10);
    tick();
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_nop",   out_pc, 0);
    chk("ovf_sticky",  32'(overflow), 1);

    // Mid-run reset clears sticky overflow
    fetch(1'b1, 32'h30, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_ovf",   32'(overflow), 0);
    chk("rst2_valid", 32'(out_valid), 0);

    // Flush with a response in flight
    fetch(1'b1, 32'h40, 1'b0); tick();
    fetch(1'b1, 32'h44, 1'b0); tick();
    flush = 1'b1;
    fetch(1'b1, 32'h20, 1'b1); tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_stall", 32'(stall_req), 0);
    fetch(1'b1, 32'h24, 1'b0); tick();
    chk("pend_valid", 32'(out_valid), 0);
    chk("pend_ovf",   32'(overflow), 0);
    fetch(1'b1, 32'h28, 1'b0); tick();
    chk("post_valid", 32'(out_valid), 1);
    chk("post_pc",    out_pc, 32'h28);
    chk("post_inst",  out_inst, inst_of(32'h28));

    // Misaligned fetch address
    fetch(1'b1, 32'h6, 1'b1); tick();
    chk("mis_pc",   out_pc, 32'h6);
    chk("mis_adel", 32'(out_exc_adel), 1);
    fetch(1'b1, 32'h8, 1'b1); tick();
    chk("al_pc",   out_pc, 32'h8);
    chk("al_adel", 32'(out_exc_adel), 0);
    fetch(1'b0, 32'h0, 1'b1); tick();
    chk("end_valid", 32'(out_valid), 0);
    chk("end_adel",  32'(out_exc_adel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
